// File: rtl/pgm8755_pkg.sv
// Shared constants and state encoding for the 8755 EPROM read path.
package pgm8755_pkg;

    localparam int ADDR_W      = 11;
    localparam int DATA_W      = 8;
    localparam int EPROM_BYTES = 2048;

    localparam logic IOM_MEM = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ALE_HI  = 3'd1,
        ALE_LO  = 3'd2,
        RD_LO   = 3'd3,
        RD_HI   = 3'd4,
        HANDOFF = 3'd5,
        FINISH  = 3'd6
    } rdr_state_t;

endpackage

// File: rtl/eprom_reader_phase_timer.sv
// Bus phase timer: counts clock cycles inside one 8755 bus phase and flags the
// last cycle; it restarts from zero whenever the reader changes state.
module phase_timer #(
    parameter int PHASE_CYCLES = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tc_o
);

    localparam int CNT_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    // next count: wrap at the terminal value or on a state change
    always_comb begin
        if (clear_i || tc_o) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/eprom_reader.sv
// 8755 EPROM reader: runs ALE/RD cycles on the multiplexed AD bus and streams
// each byte out over valid/ready. Optional running checksum: PGM8755_RDR_CHECKSUM_EN.
module eprom_reader
    import pgm8755_pkg::*;
#(
    parameter int PHASE_CYCLES = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] data_addr,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [7:0]        ad_out,
    output logic              ad_oe,
    input  logic [7:0]        ad_in,
    output logic [ADDR_W-9:0] a_hi,
    output logic              ale,
    output logic              rd_n,
    output logic              iom,
    output logic              ce
`ifdef PGM8755_RDR_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(EPROM_BYTES);

    rdr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [7:0]        ad_out_q, ad_out_d;
    logic              ad_oe_q, ad_oe_d;
    logic [ADDR_W-9:0] a_hi_q, a_hi_d;
    logic              ale_q, ale_d;
    logic              rd_n_q, rd_n_d;
    logic              ce_q, ce_d;
    logic              iom_q;
    logic              phase_tc_s;
    logic              phase_clr_s;

    assign phase_clr_s = (state_d != state_q);

    phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phase_timer (
        .clk    (clk),
        .rst    (rst),
        .clear_i(phase_clr_s),
        .tc_o   (phase_tc_s)
    );

    // sequencing: state, current address, bytes remaining, captured byte
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = (count > MAX_CNT) ? MAX_CNT : count;
                    state_d = (count == {CNT_W{1'b0}}) ? FINISH : ALE_HI;
                end else begin
                    state_d = IDLE;
                end
            end
            ALE_HI: begin
                if (phase_tc_s) state_d = ALE_LO;
                else            state_d = ALE_HI;
            end
            ALE_LO: begin
                if (phase_tc_s) state_d = RD_LO;
                else            state_d = ALE_LO;
            end
            RD_LO: begin
                if (phase_tc_s) begin
                    data_d  = ad_in;
                    state_d = RD_HI;
                end else begin
                    state_d = RD_LO;
                end
            end
            RD_HI: begin
                if (phase_tc_s) state_d = HANDOFF;
                else            state_d = RD_HI;
            end
            HANDOFF: begin
                if (data_ready) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = FINISH;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ALE_HI;
                    end
                end else begin
                    state_d = HANDOFF;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // bus and handshake outputs decoded from the state being entered, so the
    // registered pins line up with the state register
    always_comb begin
        busy_d      = 1'b0;
        done_d      = 1'b0;
        valid_d     = 1'b0;
        ad_out_d    = 8'h00;
        ad_oe_d     = 1'b0;
        a_hi_d      = {(ADDR_W-8){1'b0}};
        ale_d       = 1'b0;
        rd_n_d      = 1'b1;
        ce_d        = 1'b0;
        data_addr_d = data_addr_q;
        case (state_d)
            ALE_HI, ALE_LO: begin
                busy_d   = 1'b1;
                ce_d     = 1'b1;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d[7:0];
                a_hi_d   = addr_d[ADDR_W-1:8];
                ale_d    = (state_d == ALE_HI);
            end
            RD_LO, RD_HI: begin
                busy_d = 1'b1;
                ce_d   = 1'b1;
                a_hi_d = addr_d[ADDR_W-1:8];
                rd_n_d = (state_d != RD_LO);
            end
            HANDOFF: begin
                busy_d      = 1'b1;
                ce_d        = 1'b1;
                valid_d     = 1'b1;
                a_hi_d      = addr_d[ADDR_W-1:8];
                data_addr_d = addr_d;
            end
            FINISH:  done_d = 1'b1;
            IDLE:    busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            rem_q       <= {CNT_W{1'b0}};
            data_q      <= {DATA_W{1'b0}};
            data_addr_q <= {ADDR_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            ad_out_q    <= 8'h00;
            ad_oe_q     <= 1'b0;
            a_hi_q      <= {(ADDR_W-8){1'b0}};
            ale_q       <= 1'b0;
            rd_n_q      <= 1'b1;
            ce_q        <= 1'b0;
            iom_q       <= IOM_MEM;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            data_addr_q <= data_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            a_hi_q      <= a_hi_d;
            ale_q       <= ale_d;
            rd_n_q      <= rd_n_d;
            ce_q        <= ce_d;
            iom_q       <= IOM_MEM;
        end
    end

`ifdef PGM8755_RDR_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    // running sum of handed-off bytes, restarted by an accepted start
    always_comb begin
        if (state_q == IDLE && start) begin
            chk_d = 8'h00;
        end else if (state_q == HANDOFF && data_ready) begin
            chk_d = chk_q + data_q;
        end else begin
            chk_d = chk_q;
        end
    end

    // checksum register
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 8'h00;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign checksum = chk_q;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_q;
    assign data_addr  = data_addr_q;
    assign data_valid = valid_q;
    assign ad_out     = ad_out_q;
    assign ad_oe      = ad_oe_q;
    assign a_hi       = a_hi_q;
    assign ale        = ale_q;
    assign rd_n       = rd_n_q;
    assign iom        = iom_q;
    assign ce         = ce_q;

endmodule
